uart_rx_fifo: RTL

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 20 ++
 rtl/uart_rx_fifo_sync_fifo.sv | 60 ++++++
 rtl/uart_rx_fifo.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART definitions: frame FSM state encodings and bit-timing derivation,
// common to the receiver and transmitter.
package uart_rx_fifo_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } uart_state_t;

   function automatic int bit_period(input int clk_hz, input int sclk_hz);
      return clk_hz / sclk_hz;
   endfunction

   function automatic int half_period(input int clk_hz, input int sclk_hz);
      return bit_period(clk_hz, sclk_hz) / 2;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// First-word fall-through synchronous FIFO. Reports a dropped write when full
// with no pop in the same cycle.
module sync_fifo #(
   parameter int WIDTH      = 8,
   parameter int DEPTH_BITS = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic [WIDTH-1:0]      wr_data,
   input  logic                  rd_en,
   output logic [WIDTH-1:0]      rd_data,
   output logic [DEPTH_BITS:0]   count,
   output logic                  valid,
   output logic                  overflow
);

   localparam int DEPTH = 1 << DEPTH_BITS;

   logic [WIDTH-1:0]      mem [DEPTH];
   logic [DEPTH_BITS-1:0] wr_ptr;
   logic [DEPTH_BITS-1:0] rd_ptr;
   logic [DEPTH_BITS:0]   count_q;
   logic                  empty;
   logic                  full;
   logic                  pop;
   logic                  wr_ok;

   // count only reaches DEPTH when full, so its MSB is the full flag
   assign empty    = (count_q == '0);
   assign full     = count_q[DEPTH_BITS];
   assign pop      = rd_en && !empty;
   assign wr_ok    = wr_en && (!full || pop);
   assign overflow = wr_en && full && !pop;

   always_ff @(posedge clk) begin
      if (wr_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_q <= '0;
      end else begin
         if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
         if (pop)   rd_ptr <= rd_ptr + 1'b1;
         case ({wr_ok, pop})
            2'b10:   count_q <= count_q + 1'b1;
            2'b01:   count_q <= count_q - 1'b1;
            default: count_q <= count_q;
         endcase
      end
   end

   assign count   = count_q;
   assign valid   = !empty;
   assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver feeding a byte FIFO, with sticky framing and overrun flags.
//
// state    | meaning
// ST_IDLE  | line idle, waiting for a low level (start edge)
// ST_START | timing to start-bit centre; high there rejects it as a glitch
// ST_DATA  | sampling 8 data bits LSB first, one per bit period at centre
// ST_STOP  | sampling stop bit at centre; high pushes byte, low flags framing error
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int CLK_HZ          = 40000000,
   parameter int SCLK_HZ         = 115200,
   parameter int COUNTER_WIDTH   = 9,
   parameter int FIFO_DEPTH_BITS = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       uart_rxd,
   output logic [7:0]                 rx_data,
   output logic                       rx_valid,
   input  logic                       rx_ready,
   output logic [FIFO_DEPTH_BITS:0]   rx_count,
   output logic                       err_frame,
   output logic                       err_overrun,
   input  logic                       err_clear
);

   localparam int BIT_PERIOD = bit_period(CLK_HZ, SCLK_HZ);
   localparam int HALF       = half_period(CLK_HZ, SCLK_HZ);
   localparam logic [COUNTER_WIDTH-1:0] BIT_LAST  = COUNTER_WIDTH'(BIT_PERIOD - 1);
   localparam logic [COUNTER_WIDTH-1:0] HALF_LAST = COUNTER_WIDTH'(HALF - 1);

   logic                     rxd_meta;
   logic                     rxd_sync;
   uart_state_t              state_q,   state_d;
   logic [COUNTER_WIDTH-1:0] cnt_q,     cnt_d;
   logic [2:0]               bit_idx_q, bit_idx_d;
   logic [7:0]               shift_q,   shift_d;
   logic                     push;
   logic                     frame_err;
   logic                     fifo_overflow;

   always_ff @(posedge clk) begin
      if (reset) begin
         rxd_meta <= 1'b1;
         rxd_sync <= 1'b1;
      end else begin
         rxd_meta <= uart_rxd;
         rxd_sync <= rxd_meta;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         bit_idx_q <= '0;
         shift_q   <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_idx_q <= bit_idx_d;
         shift_q   <= shift_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_idx_d = bit_idx_q;
      shift_d   = shift_q;
      push      = 1'b0;
      frame_err = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!rxd_sync) begin
               state_d = ST_START;
               cnt_d   = '0;
            end
         end
         ST_START: begin
            if (cnt_q == HALF_LAST) begin
               cnt_d     = '0;
               bit_idx_d = '0;
               state_d   = rxd_sync ? ST_IDLE : ST_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_DATA: begin
            if (cnt_q == BIT_LAST) begin
               cnt_d     = '0;
               shift_d   = {rxd_sync, shift_q[7:1]};
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) state_d = ST_STOP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         ST_STOP: begin
            // back to IDLE at stop centre so the next start edge is caught
            if (cnt_q == BIT_LAST) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
               if (rxd_sync) push      = 1'b1;
               else          frame_err = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         err_frame   <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         if (frame_err)      err_frame <= 1'b1;
         else if (err_clear) err_frame <= 1'b0;
         if (fifo_overflow)  err_overrun <= 1'b1;
         else if (err_clear) err_overrun <= 1'b0;
      end
   end

   sync_fifo #(
      .WIDTH      (8),
      .DEPTH_BITS (FIFO_DEPTH_BITS)
   ) u_fifo (
      .clk      (clk),
      .reset    (reset),
      .wr_en    (push),
      .wr_data  (shift_q),
      .rd_en    (rx_ready),
      .rd_data  (rx_data),
      .count    (rx_count),
      .valid    (rx_valid),
      .overflow (fifo_overflow)
   );

endmodule
